sq_accumulator: RTL and testbench

Sequential sum-of-squares stage that sits directly downstream of the 2-bit squarer and consumes its 4-bit `D` output. It accepts one square per handshake, accumulates a frame of `FRAME_LEN` samples, then presents the frame sum on a valid/ready output port and holds it until the consumer takes it. The accumulator saturates instead of wrapping and reports saturation alongside the sum.

---
 rtl/sq_accumulator.sv | 110 +++++++++++
 tb/tb_sq_accumulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sq_accumulator.sv
// Sum-of-squares frame accumulator: adds FRAME_LEN 4-bit squares with saturation, presents the frame sum.
// Latency: result visible the cycle after the last sample is accepted; one dead input cycle per frame.
// Backpressure: in_ready drops while a result is held; the result stays stable until out_ready.
module sq_accumulator #(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [7:0]       sample_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_cnt;
  logic               r_sticky;
  logic [ACC_W-1:0]   r_sum;
  logic               r_sat;

  logic               w_accept;
  logic               w_last;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_ovf;
  logic [ACC_W-1:0]   w_acc_nxt;

  // One extra bit catches overflow; once acc is all-ones it stays there for the frame.
  assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-3){1'b0}}, in_data};
  assign w_ovf     = w_sum_ext[ACC_W];
  assign w_acc_nxt = w_ovf ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_accept  = in_valid & in_ready;

  assign out_sum    = r_sum;
  assign out_sat    = r_sat;
  assign sample_cnt = r_cnt;

  // State register; reset returns to ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; in_ready/out_valid depend on registered state only.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
    endcase
    // Abort wins over any handshake in the same cycle.
    if (clear) begin
      w_state_nxt = ACCUM;
    end
  end

  // Accumulator, sample counter, sticky saturation and held result.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_sum    <= '0;
      r_sat    <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_sum    <= w_acc_nxt;
        r_sat    <= r_sticky | w_ovf;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else begin
        r_acc    <= w_acc_nxt;
        r_cnt    <= r_cnt + 8'd1;
        r_sticky <= r_sticky | w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sq_accumulator.sv
// Directed bench for sq_accumulator: default frame, long saturating frame and single-sample frame.
module tb_sq_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (FRAME_LEN=4, ACC_W=8)
  logic       a_clear = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_sat;
  logic [3:0] a_in_data = 0;
  logic [7:0] a_out_sum, a_cnt;
  // Instance B: FRAME_LEN=32
  logic       b_clear = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_sat;
  logic [3:0] b_in_data = 0;
  logic [7:0] b_out_sum, b_cnt;
  // Instance C: FRAME_LEN=1
  logic       c_clear = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_out_sat;
  logic [3:0] c_in_data = 0;
  logic [7:0] c_out_sum, c_cnt;

  sq_accumulator #(.FRAME_LEN(4), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_sat(a_out_sat), .sample_cnt(a_cnt));

  sq_accumulator #(.FRAME_LEN(32), .ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_sat(b_out_sat), .sample_cnt(b_cnt));

  sq_accumulator #(.FRAME_LEN(1), .ACC_W(8)) dut_c (
    .clk(clk), .rst(rst), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_sat(c_out_sat), .sample_cnt(c_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] c_vals [4];

  initial begin
    c_vals[0] = 4'd0; c_vals[1] = 4'd1; c_vals[2] = 4'd4; c_vals[3] = 4'd9;

    // Reset
    #1;
    rst = 1'b1;
    tick();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_sum", a_out_sum, 0);
    chk("rst_out_sat", a_out_sat, 0);
    chk("rst_cnt", a_cnt, 0);
    rst = 1'b0;

    // Test 1: 0,1,4,9 continuous, out_ready high -> 14 for one cycle
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data = 4'd0; tick();
    chk("t1_cnt1", a_cnt, 1);
    a_in_data = 4'd1; tick();
    a_in_data = 4'd4; tick();
    chk("t1_cnt3", a_cnt, 3);
    chk("t1_no_valid_early", a_out_valid, 0);
    a_in_data = 4'd9; tick();
    chk("t1_out_valid", a_out_valid, 1);
    chk("t1_out_sum", a_out_sum, 14);
    chk("t1_out_sat", a_out_sat, 0);
    chk("t1_in_ready_low", a_in_ready, 0);
    chk("t1_cnt_wrap", a_cnt, 0);
    a_in_valid = 1'b0; tick();
    chk("t1_valid_one_cycle", a_out_valid, 0);
    chk("t1_in_ready_back", a_in_ready, 1);

    // Gap in in_valid mid-frame leaves count untouched
    a_in_valid = 1'b1; a_in_data = 4'd9; a_out_ready = 1'b0; tick();
    a_in_valid = 1'b0; tick(); tick();
    chk("t2_gap_cnt", a_cnt, 1);

    // Test 2: 9,9,9,9 held with out_ready low, extra in_valid ignored
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t2_out_valid", a_out_valid, 1);
    chk("t2_out_sum", a_out_sum, 36);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = i[0] ? 1'b0 : 1'b1;
      a_in_data  = 4'd15;
      tick();
      chk("t2_hold_valid", a_out_valid, 1);
      chk("t2_hold_sum", a_out_sum, 36);
      chk("t2_hold_in_ready", a_in_ready, 0);
      chk("t2_hold_cnt", a_cnt, 0);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1; tick();
    chk("t2_release_valid", a_out_valid, 0);
    chk("t2_release_cnt", a_cnt, 0);
    chk("t2_release_in_ready", a_in_ready, 1);

    // Test 4: 4,4 then clear with a simultaneous 9, then 1,1,1,1 -> 4
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 4'd4; tick(); tick();
    chk("t4_cnt2", a_cnt, 2);
    a_clear = 1'b1; a_in_data = 4'd9; tick();
    a_clear = 1'b0;
    chk("t4_clear_cnt", a_cnt, 0);
    chk("t4_clear_in_ready", a_in_ready, 1);
    a_in_data = 4'd1;
    for (int i = 0; i < 4; i++) tick();
    a_in_valid = 1'b0;
    chk("t4_out_valid", a_out_valid, 1);
    chk("t4_out_sum", a_out_sum, 4);
    // clear beats an output handshake and wipes the held result
    a_clear = 1'b1; a_out_ready = 1'b1; tick();
    a_clear = 1'b0; a_out_ready = 1'b0;
    chk("t4_clear_hold_valid", a_out_valid, 0);
    chk("t4_clear_hold_sum", a_out_sum, 0);

    // Test 5: reset while holding 14
    a_in_valid = 1'b1;
    a_in_data = 4'd0; tick();
    a_in_data = 4'd1; tick();
    a_in_data = 4'd4; tick();
    a_in_data = 4'd9; tick();
    a_in_valid = 1'b0;
    chk("t5_hold_sum", a_out_sum, 14);
    chk("t5_hold_valid", a_out_valid, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("t5_rst_valid", a_out_valid, 0);
    chk("t5_rst_sum", a_out_sum, 0);
    chk("t5_rst_in_ready", a_in_ready, 1);
    chk("t5_rst_cnt", a_cnt, 0);

    // Test 3: FRAME_LEN=32, 9 x32 saturates, then 1 x32 gives 32
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 4'd9;
    for (int i = 0; i < 31; i++) tick();
    chk("t3_cnt31", b_cnt, 31);
    chk("t3_not_done", b_out_valid, 0);
    tick();
    chk("t3_out_valid", b_out_valid, 1);
    chk("t3_out_sum", b_out_sum, 255);
    chk("t3_out_sat", b_out_sat, 1);
    b_in_data = 4'd1;
    tick();  // dead cycle: sample presented here is not taken
    chk("t3_dead_cnt", b_cnt, 0);
    for (int i = 0; i < 32; i++) tick();
    b_in_valid = 1'b0;
    chk("t3_f2_valid", b_out_valid, 1);
    chk("t3_f2_sum", b_out_sum, 32);
    chk("t3_f2_sat", b_out_sat, 0);

    // Test 6: FRAME_LEN=1, each accepted sample is a result, 2 cycles apart
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_in_data = c_vals[i];
      tick();
      chk("t6_valid", c_out_valid, 1);
      chk("t6_sum", c_out_sum, 32'(c_vals[i]));
      chk("t6_sat", c_out_sat, 0);
      tick();
      chk("t6_gap_valid", c_out_valid, 0);
    end
    c_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
